// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the DRAM-to-SRAM bridge.
package ram_ctrl_pkg;
  localparam int REFRESH_CNT_W   = 16;
  localparam int DEF_ADDR_BITS   = 9;
  localparam int DEF_NUM_BANKS   = 2;
  localparam int DEF_NUM_LANES   = 2;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {IDLE, ROW, ACCESS, REFRESH, REARM} state_e;
endpackage

// File: rtl/strobe_sync.sv
// Multi-bit synchroniser with registered edge flags; lvl is delayed to line up with the flags.
module strobe_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] lvl,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] rise
);
  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] lvl_q, lvl_d, fall_q, fall_d, rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    lvl_d  = sync_q[STAGES-1];
    fall_d = lvl_q & ~sync_q[STAGES-1];
    rise_d = ~lvl_q & sync_q[STAGES-1];
  end

  // Strobes are active low, so idle/reset value is all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      lvl_q  <= '1;
      fall_q <= '0;
      rise_q <= '0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      fall_q <= fall_d;
      rise_q <= rise_d;
    end
  end

  assign lvl  = lvl_q;
  assign fall = fall_q;
  assign rise = rise_q;
endmodule

// File: rtl/dram_sram_bridge.sv
// Rebuilds a flat SRAM access from multiplexed RAS/CAS DRAM strobes; detects CBR refresh.
// Optional refresh counter: define REFRESH_COUNTER_EN.
module dram_sram_bridge
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_BITS   = DEF_ADDR_BITS,
  parameter int NUM_BANKS   = DEF_NUM_BANKS,
  parameter int NUM_LANES   = DEF_NUM_LANES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [ADDR_BITS-1:0]     Ain,
  input  logic [NUM_BANKS-1:0]     RAS_n,
  input  logic [NUM_LANES-1:0]     CAS_n,
  input  logic                     WE_n,
  input  logic                     OE_n,
  output logic [2*ADDR_BITS-1:0]   Aout,
  output logic [NUM_BANKS-1:0]     bank_sel,
  output logic [NUM_LANES-1:0]     lane_en,
  output logic                     sram_ce_n,
  output logic                     sram_we_n,
  output logic                     sram_oe_n,
  output logic                     refresh,
  output logic [REFRESH_CNT_W-1:0] refresh_count
);
  logic [NUM_BANKS-1:0] ras_lvl, ras_fall, ras_rise;
  logic [NUM_LANES-1:0] cas_lvl, cas_fall, cas_rise;
  logic [1:0]           ctl_lvl, ctl_fall, ctl_rise;

  strobe_sync #(.WIDTH(NUM_BANKS), .STAGES(SYNC_STAGES)) u_ras_sync (
    .clk(CLK), .reset(reset), .din(RAS_n), .lvl(ras_lvl), .fall(ras_fall), .rise(ras_rise));
  strobe_sync #(.WIDTH(NUM_LANES), .STAGES(SYNC_STAGES)) u_cas_sync (
    .clk(CLK), .reset(reset), .din(CAS_n), .lvl(cas_lvl), .fall(cas_fall), .rise(cas_rise));
  strobe_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_ctl_sync (
    .clk(CLK), .reset(reset), .din({WE_n, OE_n}), .lvl(ctl_lvl), .fall(ctl_fall), .rise(ctl_rise));

  logic unused_edges;
  assign unused_edges = ^{ras_rise, cas_rise, ctl_fall, ctl_rise};

  // Address delay matches the strobe path including the edge-flag register.
  logic [SYNC_STAGES:0][ADDR_BITS-1:0] ain_q, ain_d;
  logic [ADDR_BITS-1:0] ain_al;
  always_comb ain_d = {ain_q[SYNC_STAGES-1:0], Ain};
  assign ain_al = ain_q[SYNC_STAGES];

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] row_q, row_d, col_q, col_d;
  logic [NUM_BANKS-1:0] bank_q, bank_d, ref_bank_q, ref_bank_d, ras_first;
  logic [NUM_LANES-1:0] lane_q, lane_d;
  logic ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d, refresh_q, refresh_d;
  logic found;

  always_comb begin
    ras_first = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (!ras_lvl[i] && !found) begin
        ras_first[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    bank_d     = bank_q;
    ref_bank_d = ref_bank_q;
    lane_d     = lane_q;
    ce_n_d     = ce_n_q;
    we_n_d     = we_n_q;
    oe_n_d     = oe_n_q;
    refresh_d  = 1'b0;
    case (state_q)
      REARM: if (&ras_lvl && &cas_lvl) state_d = IDLE;
      IDLE: if (|ras_fall) begin
        if (&cas_lvl) begin
          row_d   = ain_al;
          bank_d  = ras_first;
          state_d = ROW;
        end else begin
          ref_bank_d = ras_first;
          refresh_d  = 1'b1;
          state_d    = REFRESH;
        end
      end
      ROW: if (|(bank_q & ras_lvl)) begin
        bank_d  = '0;
        lane_d  = '0;
        state_d = IDLE;
      end else if (|cas_fall) begin
        col_d   = ain_al;
        lane_d  = ~cas_lvl;
        we_n_d  = ctl_lvl[1];
        state_d = ACCESS;
      end
      ACCESS: if (|(bank_q & ras_lvl)) begin
        bank_d  = '0;
        lane_d  = '0;
        ce_n_d  = 1'b1;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        state_d = IDLE;
      end else if (&cas_lvl) begin
        lane_d  = '0;
        ce_n_d  = 1'b1;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        state_d = ROW;
      end else begin
        // Late-falling lanes simply join lane_en; the column stays put.
        ce_n_d = 1'b0;
        oe_n_d = ctl_lvl[0] | ~we_n_q;
        lane_d = ~cas_lvl;
      end
      REFRESH: if (!(|(ref_bank_q & ~ras_lvl)) && &cas_lvl) begin
        ref_bank_d = '0;
        state_d    = IDLE;
      end
      default: state_d = REARM;
    endcase
  end

  // Reset lands in REARM so a DRAM cycle already in flight is never half-captured.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= REARM;
      ain_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      bank_q     <= '0;
      ref_bank_q <= '0;
      lane_q     <= '0;
      ce_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      refresh_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ain_q      <= ain_d;
      row_q      <= row_d;
      col_q      <= col_d;
      bank_q     <= bank_d;
      ref_bank_q <= ref_bank_d;
      lane_q     <= lane_d;
      ce_n_q     <= ce_n_d;
      we_n_q     <= we_n_d;
      oe_n_q     <= oe_n_d;
      refresh_q  <= refresh_d;
    end
  end

`ifdef REFRESH_COUNTER_EN
  logic [REFRESH_CNT_W-1:0] rcnt_q, rcnt_d;
  always_comb rcnt_d = rcnt_q + REFRESH_CNT_W'(refresh_d);
  always_ff @(posedge CLK) begin
    if (reset) rcnt_q <= '0;
    else       rcnt_q <= rcnt_d;
  end
  assign refresh_count = rcnt_q;
`else
  assign refresh_count = '0;
`endif

  assign Aout      = {row_q, col_q};
  assign bank_sel  = bank_q;
  assign lane_en   = lane_q;
  assign sram_ce_n = ce_n_q;
  assign sram_we_n = we_n_q;
  assign sram_oe_n = oe_n_q;
  assign refresh   = refresh_q;
endmodule
